// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Round-robin arbiter for one router output. Picks one requesting input per
//   cycle, pops it combinationally and registers the flit toward the
//   downstream output_buffer stage (en/data). Honours out_ready backpressure.
//
//   Optional feature macro: ARB_PKT_LOCK_EN
//     When defined, the grant is held on one input from a packet's first flit
//     through its tail flit. Undefined: per-flit arbitration, in_tail only
//     passes through to out_tail.
//
//   Lock FSM (ARB_PKT_LOCK_EN only):
//     state  | meaning
//     IDLE   | normal round-robin search from rr_ptr
//     LOCKED | only lock_idx may be granted until its tail flit is accepted
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_req       per-input valid
//     in_data      flat flit bus, input i at [i*DATA_W +: DATA_W]
//     in_tail      per-input tail marker
//     in_pop       combinational one-hot accept
//     out_ready    downstream can take a flit next cycle
//     en, data     registered flit toward output_buffer
//     out_tail     registered tail marker aligned with data
module output_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_req,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_tail,
  output logic [NUM_IN-1:0]        in_pop,
  input  logic                     out_ready,
  output logic                     en,
  output logic [DATA_W-1:0]        data,
  output logic                     out_tail
);

  localparam int PTR_W = $clog2(NUM_IN);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_found;
  logic [PTR_W-1:0] win_idx;
  logic             found;
  logic             accept;
  logic [PTR_W-1:0] next_ptr;

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t      lock_state;
  logic [PTR_W-1:0] lock_idx;
`endif

  // Search from rr_ptr, wrapping modulo NUM_IN (works for non power-of-two).
  always_comb begin : rr_search
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!rr_found && in_req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
`ifdef ARB_PKT_LOCK_EN
    // While locked a missing request from lock_idx is a bubble, not a hand-off.
    if (lock_state == LOCKED) begin
      found   = in_req[lock_idx];
      win_idx = lock_idx;
    end else begin
      found   = rr_found;
      win_idx = rr_idx;
    end
`else
    found   = rr_found;
    win_idx = rr_idx;
`endif
  end

  // rst_n gates the pop so nothing is accepted while reset is held.
  assign accept   = rst_n & out_ready & found;
  assign in_pop   = accept ? (NUM_IN'(1) << win_idx) : '0;
  assign next_ptr = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      data     <= '0;
      out_tail <= 1'b0;
      rr_ptr   <= '0;
`ifdef ARB_PKT_LOCK_EN
      lock_state <= IDLE;
      lock_idx   <= '0;
`endif
    end else begin
      en <= accept;
      if (accept) begin
        data     <= in_data[win_idx*DATA_W +: DATA_W];
        out_tail <= in_tail[win_idx];
        rr_ptr   <= next_ptr;
`ifdef ARB_PKT_LOCK_EN
        case (lock_state)
          IDLE: begin
            if (!in_tail[win_idx]) begin
              lock_state <= LOCKED;
              lock_idx   <= win_idx;
            end
          end
          LOCKED: begin
            if (in_tail[win_idx]) lock_state <= IDLE;
          end
          default: lock_state <= IDLE;
        endcase
`endif
      end
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
  localparam int DATA_W = 8;
  localparam int NUM_IN = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_IN-1:0]        in_req = '1;
  logic [NUM_IN*DATA_W-1:0] in_data = '0;
  logic [NUM_IN-1:0]        in_tail = '1;
  logic [NUM_IN-1:0]        in_pop;
  logic                     out_ready = 1'b1;
  logic                     en;
  logic [DATA_W-1:0]        data;
  logic                     out_tail;

  output_port_arbiter #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data),
    .in_tail(in_tail), .in_pop(in_pop), .out_ready(out_ready),
    .en(en), .data(data), .out_tail(out_tail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              t;
  } flit_t;

  flit_t exp_q[$];
  int checks = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endfunction

  // Reference model: evaluated once per cycle at the falling edge, when the
  // inputs (driven just after the rising edge) and in_pop have settled.
  int m_ptr = 0;
`ifdef ARB_PKT_LOCK_EN
  bit m_locked = 0;
  int m_lock = 0;
`endif

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_ptr = 0;
`ifdef ARB_PKT_LOCK_EN
        m_locked = 0;
        m_lock = 0;
`endif
        if (clk == 1'b0) check("pop_in_reset", 64'(in_pop), 64'd0);
      end else begin
        int g;
        logic [NUM_IN-1:0] exp_pop;
        g = -1;
`ifdef ARB_PKT_LOCK_EN
        if (m_locked) begin
          if (in_req[m_lock]) g = m_lock;
        end else
`endif
        for (int k = 0; k < NUM_IN; k++) begin
          if (g < 0 && in_req[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
        end
        exp_pop = '0;
        if (out_ready && g >= 0) exp_pop[g] = 1'b1;
        check("in_pop", 64'(in_pop), 64'(exp_pop));
        if (out_ready && g >= 0) begin
          exp_q.push_back({in_data[g*DATA_W +: DATA_W], in_tail[g]});
          m_ptr = (g + 1) % NUM_IN;
`ifdef ARB_PKT_LOCK_EN
          if (!m_locked && !in_tail[g]) begin
            m_locked = 1;
            m_lock = g;
          end else if (m_locked && in_tail[g]) begin
            m_locked = 0;
          end
`endif
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a flit.
  logic [DATA_W-1:0] last_d = '0;
  logic              last_t = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        last_d = '0;
        last_t = 1'b0;
        check("en_reset", 64'(en), 64'd0);
        check("data_reset", 64'(data), 64'd0);
        check("tail_reset", 64'(out_tail), 64'd0);
      end else if (en) begin
        if (exp_q.size() == 0) begin
          check("en_unexpected", 64'(en), 64'd0);
        end else begin
          flit_t f;
          f = exp_q.pop_front();
          check("data", 64'(data), 64'(f.d));
          check("out_tail", 64'(out_tail), 64'(f.t));
          last_d = f.d;
          last_t = f.t;
        end
      end else if (exp_q.size() != 0) begin
        check("en_missing", 64'(en), 64'd1);
        void'(exp_q.pop_front());
      end else begin
        check("data_hold", 64'(data), 64'(last_d));
        check("tail_hold", 64'(out_tail), 64'(last_t));
      end
    end
  end

  task automatic drive(input logic [NUM_IN-1:0] r, input logic [NUM_IN*DATA_W-1:0] d,
                       input logic [NUM_IN-1:0] t, input logic rdy);
    @(posedge clk);
    #1;
    in_req    = r;
    in_data   = d;
    in_tail   = t;
    out_ready = rdy;
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #1;
    rst_n = v;
  endtask

  logic [NUM_IN*DATA_W-1:0] base;
  logic [NUM_IN*DATA_W-1:0] pkt0, pkt1, pkt2;

  initial begin
    base = {8'h13, 8'h12, 8'h11, 8'h10};
    pkt0 = {8'h13, 8'hA0, 8'h11, 8'h10};
    pkt1 = {8'h13, 8'hA1, 8'h11, 8'h10};
    pkt2 = {8'h13, 8'hA2, 8'h11, 8'h10};
    in_data = base;

    // reset held three cycles with all inputs requesting
    repeat (3) @(posedge clk);
    set_reset(1'b1);

    // fair rotation, then backpressure, then resume
    repeat (5) drive(4'b1111, base, 4'b1111, 1'b1);
    repeat (3) drive(4'b1111, base, 4'b1111, 1'b0);
    repeat (4) drive(4'b1111, base, 4'b1111, 1'b1);

    // wrap and sparse requests
    drive(4'b0100, base, 4'b1111, 1'b1);
    drive(4'b0010, base, 4'b1111, 1'b1);
    drive(4'b1001, base, 4'b1111, 1'b1);

    // bring pointer to input 2, then a 3-flit packet with a request gap
    drive(4'b0011, base, 4'b1111, 1'b1);
    drive(4'b0011, base, 4'b1111, 1'b1);
    drive(4'b0111, pkt0, 4'b1011, 1'b1);
    drive(4'b0011, pkt0, 4'b1011, 1'b1);
    drive(4'b0111, pkt1, 4'b1011, 1'b1);
    drive(4'b1111, pkt2, 4'b1111, 1'b1);
    drive(4'b0011, base, 4'b1111, 1'b1);

    // packet interrupted by reset
    drive(4'b0111, pkt0, 4'b1011, 1'b1);
    drive(4'b0111, pkt1, 4'b1011, 1'b1);
    set_reset(1'b0);
    @(posedge clk);
    set_reset(1'b1);
    repeat (3) drive(4'b0111, pkt2, 4'b1111, 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_IN*DATA_W-1:0] rd;
      for (int b = 0; b < NUM_IN; b++) rd[b*DATA_W +: DATA_W] = DATA_W'($urandom);
      drive(NUM_IN'($urandom), rd, NUM_IN'($urandom), ($urandom_range(3) != 0));
    end

    // drain
    repeat (4) drive('0, '0, '0, 1'b1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
